// File: rtl/axi_reg_slice_pkg.sv
// Shared types for the AXI register slice.
// Holds the bus widths, the five channel payload structs (each carries its own
// `valid` member), the per-channel slice mode encoding and the slice FSM states.
package axi_reg_slice_pkg;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned ID_W    = 4;
    localparam int unsigned STRB_W  = DATA_W / 8;
    localparam int unsigned LEN_W   = 8;
    localparam int unsigned SIZE_W  = 3;
    localparam int unsigned BURST_W = 2;
    localparam int unsigned RESP_W  = 2;

    // Per-channel slice behaviour.
    typedef enum logic [1:0] {
        SLICE_BYPASS = 2'd0,
        SLICE_FULL   = 2'd1,
        SLICE_LIGHT  = 2'd2
    } slice_mode_e;

    // Occupancy of a registered channel; light mode only uses EMPTY/ONE.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } slice_state_e;

    typedef struct packed {
        logic               valid;
        logic [ID_W-1:0]    id;
        logic [ADDR_W-1:0]  addr;
        logic [LEN_W-1:0]   len;
        logic [SIZE_W-1:0]  size;
        logic [BURST_W-1:0] burst;
    } aw_t;

    typedef struct packed {
        logic               valid;
        logic [ID_W-1:0]    id;
        logic [ADDR_W-1:0]  addr;
        logic [LEN_W-1:0]   len;
        logic [SIZE_W-1:0]  size;
        logic [BURST_W-1:0] burst;
    } ar_t;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] data;
        logic [STRB_W-1:0] strb;
        logic              last;
    } w_t;

    typedef struct packed {
        logic              valid;
        logic [ID_W-1:0]   id;
        logic [RESP_W-1:0] resp;
    } b_t;

    typedef struct packed {
        logic              valid;
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
        logic [RESP_W-1:0] resp;
        logic              last;
    } r_t;

    // Maps the integer mode parameters (0/1/2) onto the enum; unknown values
    // fall back to the full skid buffer as the safest timing choice.
    function automatic slice_mode_e to_mode(input int unsigned mode);
        case (mode)
            0:       to_mode = SLICE_BYPASS;
            2:       to_mode = SLICE_LIGHT;
            default: to_mode = SLICE_FULL;
        endcase
    endfunction

endpackage

// File: rtl/axi_reg_slice_if.sv
// AXI bundle between a bus master and a bus slave.
// Payload structs carry valid; the ready strobes travel against the payload.
//   master modport: drives aw, w, ar, bready, rready; receives the rest
//   slave  modport: mirror image of master
interface axi_reg_slice_if;
    import axi_reg_slice_pkg::*;

    aw_t  aw;
    logic awready;
    w_t   w;
    logic wready;
    b_t   b;
    logic bready;
    ar_t  ar;
    logic arready;
    r_t   r;
    logic rready;

    modport master (
        output aw, w, ar, bready, rready,
        input  awready, wready, arready, b, r
    );

    modport slave (
        input  aw, w, ar, bready, rready,
        output awready, wready, arready, b, r
    );

endinterface

// File: rtl/axi_reg_slice_chan.sv
// One valid/ready channel stage of the register slice.
// MODE selects a wire-through bypass, a 2-entry skid buffer (full rate) or a
// single register (half rate). Registered modes cut every path between the
// two sides: in_ready and out_data come straight from flops.
//   clk, rst   : clock, asynchronous active-high reset (bypass ignores both)
//   in_data    : producer payload, transfer when in_data.valid && in_ready
//   in_ready   : back-pressure to the producer
//   out_data   : consumer payload, out_data.valid qualifies it
//   out_ready  : back-pressure from the consumer
module axi_reg_slice_chan
    import axi_reg_slice_pkg::*;
#(
    parameter type         T    = w_t,
    parameter slice_mode_e MODE = SLICE_FULL
) (
    input  logic clk,
    input  logic rst,
    input  T     in_data,
    output logic in_ready,
    output T     out_data,
    input  logic out_ready
);

    if (MODE == SLICE_BYPASS) begin : g_bypass
        assign out_data = in_data;
        assign in_ready = out_ready;

        // Bypass holds no state, so clock and reset are intentionally dropped.
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst;
    end else begin : g_reg
        slice_state_e state_q;
        slice_state_e state_d;
        T             main_q;
        T             skid_q;
        logic         ready_q;
        logic         out_valid;
        logic         in_xfer;
        logic         out_xfer;
        logic         load_main;
        logic         load_skid;
        logic         shift_skid;

        assign out_valid = (state_q != ST_EMPTY);
        assign in_xfer   = in_data.valid && ready_q;
        assign out_xfer  = out_valid && out_ready;

        // State register; ready is precomputed from the next state so that it
        // leaves a flop and never depends on out_ready combinationally.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q <= ST_EMPTY;
                ready_q <= 1'b0;
            end else begin
                state_q <= state_d;
                if (MODE == SLICE_LIGHT) begin
                    ready_q <= (state_d == ST_EMPTY);
                end else begin
                    ready_q <= (state_d != ST_TWO);
                end
            end
        end

        // Next-state logic. In light mode ready is low in ST_ONE, so in_xfer
        // cannot occur there and ST_TWO is never reached.
        always_comb begin
            state_d = state_q;
            case (state_q)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (in_xfer && !out_xfer) begin
                        state_d = ST_TWO;
                    end else if (out_xfer && !in_xfer) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (out_xfer) begin
                        state_d = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end

        // Datapath steering derived from the current state and handshakes.
        always_comb begin
            load_main  = 1'b0;
            load_skid  = 1'b0;
            shift_skid = 1'b0;
            case (state_q)
                ST_EMPTY: load_main = in_xfer;
                ST_ONE: begin
                    load_main = in_xfer && out_xfer;
                    load_skid = in_xfer && !out_xfer;
                end
                ST_TWO:   shift_skid = out_xfer;
                default: ;
            endcase
        end

        // Payload holding registers; contents are don't-care while empty, so
        // they carry no reset and only change on a load, keeping out stable
        // under back-pressure.
        always_ff @(posedge clk) begin
            if (load_main) begin
                main_q <= in_data;
            end else if (shift_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_data;
            end
        end

        always_comb begin
            out_data       = main_q;
            out_data.valid = out_valid;
        end

        assign in_ready = ready_q;
    end

endmodule

// File: rtl/axi_reg_slice.sv
// AXI register slice: one independently configured stage per channel.
// AW, W and AR flow from s to m; B and R flow from m back to s.
//   clk, rst : clock, asynchronous active-high reset
//   s        : upstream side, faces the bus master
//   m        : downstream side, faces the bus slave
//   *_MODE   : 0 bypass, 1 full skid buffer, 2 light single register
module axi_reg_slice
    import axi_reg_slice_pkg::*;
#(
    parameter int unsigned AW_MODE = 1,
    parameter int unsigned W_MODE  = 1,
    parameter int unsigned B_MODE  = 1,
    parameter int unsigned AR_MODE = 1,
    parameter int unsigned R_MODE  = 1
) (
    input  logic             clk,
    input  logic             rst,
    axi_reg_slice_if.slave   s,
    axi_reg_slice_if.master  m
);

    axi_reg_slice_chan #(.T(aw_t), .MODE(to_mode(AW_MODE))) u_aw (
        .clk       (clk),
        .rst       (rst),
        .in_data   (s.aw),
        .in_ready  (s.awready),
        .out_data  (m.aw),
        .out_ready (m.awready)
    );

    axi_reg_slice_chan #(.T(w_t), .MODE(to_mode(W_MODE))) u_w (
        .clk       (clk),
        .rst       (rst),
        .in_data   (s.w),
        .in_ready  (s.wready),
        .out_data  (m.w),
        .out_ready (m.wready)
    );

    axi_reg_slice_chan #(.T(ar_t), .MODE(to_mode(AR_MODE))) u_ar (
        .clk       (clk),
        .rst       (rst),
        .in_data   (s.ar),
        .in_ready  (s.arready),
        .out_data  (m.ar),
        .out_ready (m.arready)
    );

    // Response channels: the downstream slave is the producer.
    axi_reg_slice_chan #(.T(b_t), .MODE(to_mode(B_MODE))) u_b (
        .clk       (clk),
        .rst       (rst),
        .in_data   (m.b),
        .in_ready  (m.bready),
        .out_data  (s.b),
        .out_ready (s.bready)
    );

    axi_reg_slice_chan #(.T(r_t), .MODE(to_mode(R_MODE))) u_r (
        .clk       (clk),
        .rst       (rst),
        .in_data   (m.r),
        .in_ready  (m.rready),
        .out_data  (s.r),
        .out_ready (s.rready)
    );

endmodule

// File: tb/tb_axi_reg_slice.sv
// Scoreboard bench for axi_reg_slice with AW/W/AR full, B bypass, R light.
module tb_axi_reg_slice;
    import axi_reg_slice_pkg::*;

    typedef struct {
        logic [31:0] val;
        longint      cyc;
    } exp_t;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    longint cyc = 0;
    int     n_tests = 0;
    int     n_fail  = 0;

    exp_t        aw_q[$];
    exp_t        ar_q[$];
    logic [31:0] w_q[$];
    logic [31:0] r_q[$];
    logic [31:0] b_q[$];
    longint      r_acc[$];
    int          w_acc = 0;
    int          w_out = 0;
    int          aw_out = 0;
    int          ar_run = 0;
    int          ar_max = 0;

    axi_reg_slice_if s_if ();
    axi_reg_slice_if m_if ();

    axi_reg_slice #(
        .AW_MODE(1), .W_MODE(1), .B_MODE(0), .AR_MODE(1), .R_MODE(2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .s   (s_if),
        .m   (m_if)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    task automatic check(input string name, input longint unsigned got, input longint unsigned exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: handshake timeout (t=%0t)", name, $time);
    endtask

    task automatic send_aw(input logic [31:0] addr, input bit track);
        s_if.aw = '0;
        s_if.aw.valid = 1'b1;
        s_if.aw.addr = addr;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (s_if.awready) begin
                if (track) aw_q.push_back('{addr, cyc + 1});
                @(posedge clk);
                #1;
                return;
            end
        end
        timeout("aw_send");
    endtask

    task automatic send_ar(input logic [31:0] addr);
        s_if.ar = '0;
        s_if.ar.valid = 1'b1;
        s_if.ar.addr = addr;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (s_if.arready) begin
                ar_q.push_back('{addr, cyc + 1});
                @(posedge clk);
                #1;
                return;
            end
        end
        timeout("ar_send");
    endtask

    task automatic send_w(input logic [31:0] data);
        s_if.w = '0;
        s_if.w.valid = 1'b1;
        s_if.w.data = data;
        s_if.w.strb = 4'hF;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (s_if.wready) begin
                w_q.push_back(data);
                w_acc++;
                @(posedge clk);
                #1;
                return;
            end
        end
        timeout("w_send");
    endtask

    task automatic send_r(input logic [31:0] data);
        m_if.r = '0;
        m_if.r.valid = 1'b1;
        m_if.r.data = data;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (m_if.rready) begin
                r_q.push_back(data);
                r_acc.push_back(cyc);
                @(posedge clk);
                #1;
                return;
            end
        end
        timeout("r_send");
    endtask

    // AW monitor: every beat must be expected, in order, one cycle after acceptance.
    initial forever begin
        @(negedge clk);
        if (m_if.aw.valid && m_if.awready) begin
            aw_out++;
            if (aw_q.size() == 0) begin
                timeout("aw_unexpected_beat");
            end else begin
                exp_t e;
                e = aw_q.pop_front();
                check("aw_addr", 64'(m_if.aw.addr), 64'(e.val));
                check("aw_latency", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    // AR monitor with valid run-length tracking.
    initial forever begin
        @(negedge clk);
        if (m_if.ar.valid) ar_run++;
        else ar_run = 0;
        if (ar_run > ar_max) ar_max = ar_run;
        if (m_if.ar.valid && m_if.arready) begin
            if (ar_q.size() == 0) begin
                timeout("ar_unexpected_beat");
            end else begin
                exp_t e;
                e = ar_q.pop_front();
                check("ar_addr", 64'(m_if.ar.addr), 64'(e.val));
                check("ar_latency", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    // W monitor with payload stability check while stalled.
    initial begin
        bit stall = 1'b0;
        w_t prev = '0;
        forever begin
            @(negedge clk);
            if (stall) check("w_stable", 64'(m_if.w), 64'(prev));
            if (m_if.w.valid && m_if.wready) begin
                w_out++;
                if (w_q.size() == 0) timeout("w_unexpected_beat");
                else check("w_data", 64'(m_if.w.data), 64'(w_q.pop_front()));
            end
            stall = m_if.w.valid && !m_if.wready && !rst;
            prev = m_if.w;
        end
    end

    initial forever begin
        @(negedge clk);
        if (s_if.r.valid && s_if.rready) begin
            if (r_q.size() == 0) timeout("r_unexpected_beat");
            else check("r_data", 64'(s_if.r.data), 64'(r_q.pop_front()));
        end
    end

    initial forever begin
        @(negedge clk);
        if (s_if.b.valid && s_if.bready) begin
            if (b_q.size() == 0) timeout("b_unexpected_beat");
            else check("b_id", 64'(s_if.b.id), 64'(b_q.pop_front()));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        s_if.aw = '0; s_if.w = '0; s_if.ar = '0;
        s_if.bready = 1'b0; s_if.rready = 1'b0;
        m_if.awready = 1'b0; m_if.wready = 1'b0; m_if.arready = 1'b0;
        m_if.b = '0; m_if.r = '0;

        // Reset and idle
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_awready", 64'(s_if.awready), 0);
        check("rst_wready", 64'(s_if.wready), 0);
        check("rst_arready", 64'(s_if.arready), 0);
        check("rst_rready", 64'(m_if.rready), 0);
        check("rst_aw_valid", 64'(m_if.aw.valid), 0);
        check("rst_w_valid", 64'(m_if.w.valid), 0);
        check("rst_ar_valid", 64'(m_if.ar.valid), 0);
        check("rst_r_valid", 64'(s_if.r.valid), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rel_awready", 64'(s_if.awready), 1);
        check("rel_wready", 64'(s_if.wready), 1);
        check("rel_arready", 64'(s_if.arready), 1);
        check("rel_rready", 64'(m_if.rready), 1);

        // Full-mode streaming on AR
        m_if.arready = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) send_ar(32'(i));
        s_if.ar = '0;
        repeat (3) @(negedge clk);
        check("ar_valid_run", 64'(ar_max), 16);
        check("ar_drained", 64'(ar_q.size()), 0);

        // Full-mode back-pressure on W
        m_if.wready = 1'b0;
        @(posedge clk);
        #1;
        fork
            begin
                send_w(32'hA1);
                send_w(32'hA2);
                send_w(32'hA3);
                s_if.w = '0;
            end
            begin
                repeat (4) @(negedge clk);
                check("w_ready_drop", 64'(s_if.wready), 0);
                check("w_accepted_before_drop", 64'(w_acc), 2);
                check("w_hold_valid", 64'(m_if.w.valid), 1);
                check("w_hold_data", 64'(m_if.w.data), 64'h00A1);
                @(negedge clk);
                check("w_hold_data2", 64'(m_if.w.data), 64'h00A1);
                @(posedge clk);
                #1 m_if.wready = 1'b1;
            end
        join
        repeat (4) @(negedge clk);
        check("w_drained", 64'(w_q.size()), 0);
        check("w_out_count", 64'(w_out), 3);

        // Light mode on R
        s_if.rready = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 8; k++) send_r(32'hB0 + 32'(k));
        m_if.r = '0;
        repeat (4) @(negedge clk);
        check("r_beats", 64'(r_acc.size()), 8);
        if (r_acc.size() == 8) begin
            for (int k = 1; k < 8; k++) check("r_gap", 64'(r_acc[k] - r_acc[k-1]), 2);
            check("r_span", 64'(r_acc[7] - r_acc[0] + 2), 16);
        end
        check("r_drained", 64'(r_q.size()), 0);

        // Bypass on B
        @(posedge clk);
        #1;
        s_if.bready = 1'b0;
        m_if.b = '0;
        m_if.b.valid = 1'b1;
        m_if.b.id = 4'h5;
        m_if.b.resp = 2'h2;
        #1;
        check("b_valid_same_cycle", 64'(s_if.b.valid), 1);
        check("b_id_same_cycle", 64'(s_if.b.id), 5);
        check("b_resp_same_cycle", 64'(s_if.b.resp), 2);
        check("b_ready_low", 64'(m_if.bready), 0);
        b_q.push_back(32'h5);
        s_if.bready = 1'b1;
        #1;
        check("b_ready_high", 64'(m_if.bready), 1);
        @(posedge clk);
        #1;
        m_if.b = '0;
        s_if.bready = 1'b0;
        #1;
        check("b_ready_low2", 64'(m_if.bready), 0);
        check("b_drained", 64'(b_q.size()), 0);

        // Reset with two beats held in AW
        m_if.awready = 1'b0;
        @(posedge clk);
        #1;
        send_aw(32'h10, 1'b0);
        send_aw(32'h20, 1'b0);
        s_if.aw = '0;
        @(negedge clk);
        check("aw_held_valid", 64'(m_if.aw.valid), 1);
        check("aw_held_addr", 64'(m_if.aw.addr), 64'h10);
        check("aw_full_ready", 64'(s_if.awready), 0);
        #2 rst = 1'b1;
        #1;
        check("aw_async_clear", 64'(m_if.aw.valid), 0);
        check("aw_rst_ready", 64'(s_if.awready), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        m_if.awready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("aw_no_stale", 64'(m_if.aw.valid), 0);
        end
        @(posedge clk);
        #1;
        send_aw(32'h40, 1'b1);
        s_if.aw = '0;
        repeat (3) @(negedge clk);
        check("aw_drained", 64'(aw_q.size()), 0);
        check("aw_out_count", 64'(aw_out), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
